// File: rtl/cpu_consts.sv
// Shared execute-stage constants: branch funct3 encodings, BHT counter type, BHT FSM states.
package cpu_consts;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  typedef enum logic {
    BHT_INIT = 1'b0,
    BHT_RUN  = 1'b1
  } bht_state_e;

  // 2-bit saturating counter step: never wraps past 3 or below 0.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Pure B-type condition evaluator; non-branches and reserved funct3 codes resolve not-taken.
module branch_cond
  import cpu_consts::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic [2:0]      funct3,
  input  logic            is_b_type,
  output logic            taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (opr_a == opr_b);
      F3_BNE:  cond = (opr_a != opr_b);
      F3_BLT:  cond = ($signed(opr_a) <  $signed(opr_b));
      F3_BGE:  cond = ($signed(opr_a) >= $signed(opr_b));
      F3_BLTU: cond = (opr_a <  opr_b);
      F3_BGEU: cond = (opr_a >= opr_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken = is_b_type & cond;

endmodule

// File: rtl/branch_unit.sv
// Branch resolve with BHT prediction: combinational lookup, resolve outputs registered one cycle later.
// The BHT is swept to CTR_INIT for BHT_ENTRIES cycles after reset; predictions read 0 until then.
module branch_unit
  import cpu_consts::*;
#(
  parameter int       XLEN        = 64,
  parameter int       BHT_ENTRIES = 64,
  parameter bht_ctr_t CTR_INIT    = 2'b01,
  parameter int       PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid_i,
  input  logic [XLEN-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  input  logic              res_valid_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic [XLEN-1:0]   opr_a_i,
  input  logic [XLEN-1:0]   opr_b_i,
  input  logic              is_b_type_i,
  input  logic [2:0]        instr_funct3_i,
  input  logic              res_pred_taken_i,
  input  logic [XLEN-1:0]   res_target_i,
  input  logic              flush_i,
  output logic              res_valid_o,
  output logic              branch_taken_o,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              init_done_o,
  output logic [PERF_W-1:0] branch_cnt_o,
  output logic [PERF_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_state_e      state_q;
  logic [IDX_W-1:0] init_ptr_q;
  bht_ctr_t        bht [BHT_ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond_taken;
  logic             res_fire;
  logic             res_br;
  logic             res_mispred;
  logic             unused_pc_bits;

  assign pred_idx       = pred_pc_i[IDX_W+1:2];
  assign res_idx        = res_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0]};

  branch_cond #(
    .XLEN(XLEN)
  ) u_cond (
    .opr_a     (opr_a_i),
    .opr_b     (opr_b_i),
    .funct3    (instr_funct3_i),
    .is_b_type (is_b_type_i),
    .taken     (cond_taken)
  );

  assign res_fire    = res_valid_i & ~flush_i;
  assign res_br      = res_fire & is_b_type_i;
  assign res_mispred = is_b_type_i & (cond_taken ^ res_pred_taken_i);

  assign init_done_o  = (state_q == BHT_RUN);
  // Reads the stored value only: a same-cycle update at this index shows next cycle.
  assign pred_taken_o = pred_valid_i & init_done_o & bht[pred_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BHT_INIT;
      init_ptr_q <= '0;
    end else if (state_q == BHT_INIT) begin
      init_ptr_q <= init_ptr_q + 1'b1;
      if (init_ptr_q == IDX_W'(BHT_ENTRIES - 1)) begin
        state_q <= BHT_RUN;
      end
    end
  end

  // Single write port: the init sweep owns it until RUN, so resolves never train during INIT.
  always_ff @(posedge clk) begin
    if (state_q == BHT_INIT) begin
      bht[init_ptr_q] <= CTR_INIT;
    end else if (res_br) begin
      bht[res_idx] <= ctr_next(bht[res_idx], cond_taken);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_o    <= 1'b0;
      branch_taken_o <= 1'b0;
      mispredict_o   <= 1'b0;
      redirect_pc_o  <= '0;
    end else begin
      res_valid_o <= res_fire;
      if (res_fire) begin
        branch_taken_o <= cond_taken;
        mispredict_o   <= res_mispred;
        redirect_pc_o  <= cond_taken ? res_target_i : res_pc_i + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (res_br && !(&branch_cnt_o)) begin
        branch_cnt_o <= branch_cnt_o + 1'b1;
      end
      if (res_br && res_mispred && !(&mispred_cnt_o)) begin
        mispred_cnt_o <= mispred_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: vector table for the comparator, scoreboard for the registered resolve path.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid_i;
  logic [63:0] pred_pc_i;
  logic        pred_taken_o;
  logic        res_valid_i;
  logic [63:0] res_pc_i;
  logic [63:0] opr_a_i;
  logic [63:0] opr_b_i;
  logic        is_b_type_i;
  logic [2:0]  instr_funct3_i;
  logic        res_pred_taken_i;
  logic [63:0] res_target_i;
  logic        flush_i;
  logic        res_valid_o;
  logic        branch_taken_o;
  logic        mispredict_o;
  logic [63:0] redirect_pc_o;
  logic        init_done_o;
  logic [3:0]  branch_cnt_o;
  logic [3:0]  mispred_cnt_o;

  always #5 clk = ~clk;

  branch_unit #(
    .XLEN(64), .BHT_ENTRIES(64), .CTR_INIT(2'b01), .PERF_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .opr_a_i(opr_a_i), .opr_b_i(opr_b_i),
    .is_b_type_i(is_b_type_i), .instr_funct3_i(instr_funct3_i),
    .res_pred_taken_i(res_pred_taken_i), .res_target_i(res_target_i), .flush_i(flush_i),
    .res_valid_o(res_valid_o), .branch_taken_o(branch_taken_o), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .init_done_o(init_done_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  typedef struct {
    logic        v;
    logic        tk;
    logic        mp;
    logic [63:0] pc;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } exp_t;

  typedef struct {
    logic        isb;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic        pt;
    logic        tk;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[11];
  logic        m_tk, m_mp;
  logic [63:0] m_pc;
  logic [3:0]  m_bc, m_mc;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic isb, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                       input logic [63:0] tgt, input logic pt, input logic exp_tk);
    exp_t e;
    res_valid_i = v; flush_i = fl; is_b_type_i = isb; instr_funct3_i = f3;
    opr_a_i = a; opr_b_i = b; res_pc_i = pc; res_target_i = tgt; res_pred_taken_i = pt;
    if (v && !fl) begin
      m_tk = exp_tk;
      m_mp = isb & (exp_tk ^ pt);
      m_pc = exp_tk ? tgt : pc + 64'd4;
      if (isb && m_bc != 4'hF) m_bc = m_bc + 4'd1;
      if (m_mp && m_mc != 4'hF) m_mc = m_mc + 4'd1;
    end
    e.v = v & ~fl; e.tk = m_tk; e.mp = m_mp; e.pc = m_pc; e.bc = m_bc; e.mc = m_mc;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected one entry");
    end else begin
      e = sb.pop_front();
      chk("res_valid", res_valid_o, e.v);
      chk("branch_taken", branch_taken_o, e.tk);
      chk("mispredict", mispredict_o, e.mp);
      chk("redirect_pc", redirect_pc_o, e.pc);
      chk("branch_cnt", branch_cnt_o, e.bc);
      chk("mispred_cnt", mispred_cnt_o, e.mc);
    end
    res_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic idle_cyc();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic res_cyc(input logic isb, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] pc, input logic [63:0] tgt,
                         input logic pt, input logic tk);
    drive(1'b1, 1'b0, isb, f3, a, b, pc, tgt, pt, tk);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    res_valid_i = 1'b0;
    flush_i = 1'b0;
    sb.delete();
    m_tk = 1'b0; m_mp = 1'b0; m_pc = 64'd0; m_bc = 4'd0; m_mc = 4'd0;
    @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid_o, 1'b0);
    chk("rst_branch_taken", branch_taken_o, 1'b0);
    chk("rst_mispredict", mispredict_o, 1'b0);
    chk("rst_redirect_pc", redirect_pc_o, 64'd0);
    chk("rst_init_done", init_done_o, 1'b0);
    chk("rst_branch_cnt", branch_cnt_o, 4'd0);
    chk("rst_mispred_cnt", mispred_cnt_o, 4'd0);
    reset = 1'b0;
  endtask

  task automatic wait_init(input int start, input string name);
    int got;
    got = 0;
    for (int i = start; i <= 200; i++) begin
      idle_cyc();
      if (init_done_o) begin
        got = i;
        break;
      end
      chk("pred_in_init", pred_taken_o, 1'b0);
    end
    chk(name, got, 64);
  endtask

  initial begin
    reset = 1'b1;
    pred_valid_i = 1'b1; pred_pc_i = 64'h0;
    res_valid_i = 1'b0; res_pc_i = '0; opr_a_i = '0; opr_b_i = '0; is_b_type_i = 1'b0;
    instr_funct3_i = 3'b000; res_pred_taken_i = 1'b0; res_target_i = '0; flush_i = 1'b0;

    vt[0]  = '{1'b1, 3'b100, ALL1, 64'd1, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 3'b110, ALL1, 64'd1, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 3'b101, ALL1, 64'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 3'b111, ALL1, 64'd1, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 3'b000, 64'd5, 64'd5, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 3'b001, 64'd5, 64'd5, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 3'b010, 64'd5, 64'd5, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 3'b011, 64'd5, 64'd5, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'b000, 64'd5, 64'd5, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 3'b100, 64'd1, ALL1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 3'b110, 64'd1, ALL1, 1'b0, 1'b1};

    // Init sweep, with one resolve during INIT at index 1 that must not train the table.
    do_reset();
    idle_cyc();
    chk("init_done_c1", init_done_o, 1'b0);
    idle_cyc();
    chk("init_done_c2", init_done_o, 1'b0);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd0, 64'h4, 64'h40, 1'b0, 1'b1);
    chk("init_done_c3", init_done_o, 1'b0);
    chk("pred_in_init", pred_taken_o, 1'b0);
    wait_init(4, "init_cycles");
    pred_pc_i = 64'h0;
    #1 chk("pred_after_init", pred_taken_o, 1'b0);
    pred_pc_i = 64'h4;
    #1 chk("pred_no_init_train", pred_taken_o, 1'b0);

    // Comparator sweep from the vector table.
    for (int i = 0; i < 11; i++) begin
      res_cyc(vt[i].isb, vt[i].f3, vt[i].a, vt[i].b, 64'h2040 + 64'(i * 4),
              64'h9000 + 64'(i * 16), vt[i].pt, vt[i].tk);
    end

    // Training at 0x1000; first update also checks the no-bypass lookup.
    pred_pc_i = 64'h1000;
    #1 chk("pred_train_start", pred_taken_o, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'd0, 64'd0, 64'h1000, 64'h1100, 1'b0, 1'b1);
    #1 chk("pred_same_cycle_old", pred_taken_o, 1'b0);
    tick();
    chk("pred_next_cycle_new", pred_taken_o, 1'b1);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd0, 64'h1000, 64'h1100, 1'b1, 1'b1);
    chk("pred_tk2", pred_taken_o, 1'b1);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd0, 64'h1000, 64'h1100, 1'b1, 1'b1);
    chk("pred_tk3", pred_taken_o, 1'b1);
    pred_pc_i = 64'h1000 + 64'd256;
    #1 chk("pred_alias", pred_taken_o, 1'b1);
    pred_pc_i = 64'h1000;
    res_cyc(1'b1, 3'b000, 64'd0, 64'd1, 64'h1000, 64'h1100, 1'b1, 1'b0);
    chk("pred_nt1_sat_hi", pred_taken_o, 1'b1);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd1, 64'h1000, 64'h1100, 1'b1, 1'b0);
    chk("pred_nt2", pred_taken_o, 1'b0);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd1, 64'h1000, 64'h1100, 1'b0, 1'b0);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd1, 64'h1000, 64'h1100, 1'b0, 1'b0);
    chk("pred_nt4", pred_taken_o, 1'b0);
    res_cyc(1'b1, 3'b000, 64'd0, 64'd0, 64'h1000, 64'h1100, 1'b0, 1'b1);
    chk("pred_sat_lo", pred_taken_o, 1'b0);

    // Flushed taken resolve: no output, no training, no counting.
    drive(1'b1, 1'b1, 1'b1, 3'b000, 64'd0, 64'd0, 64'h1000, 64'h1100, 1'b0, 1'b1);
    tick();
    chk("pred_after_flush", pred_taken_o, 1'b0);

    // Redirect, mispredict, PC wrap, and hold on an idle cycle.
    res_cyc(1'b1, 3'b000, 64'd5, 64'd5, 64'h3000, 64'h2000, 1'b0, 1'b1);
    res_cyc(1'b1, 3'b001, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234, 1'b0, 1'b0);
    idle_cyc();

    // Counter saturation at PERF_W = 4.
    for (int i = 0; i < 20; i++) begin
      res_cyc(1'b1, 3'b000, 64'd3, 64'd3, 64'h80, 64'h800, 1'b0, 1'b1);
    end
    chk("mispred_cnt_sat", mispred_cnt_o, 4'hF);
    chk("branch_cnt_sat", branch_cnt_o, 4'hF);

    // Reset in the middle of INIT restarts the full sweep.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      idle_cyc();
    end
    chk("init_done_mid", init_done_o, 1'b0);
    do_reset();
    wait_init(1, "init_cycles_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised, sequential successor to the combinational branch comparator in the execute stage.
- Adds a PC-indexed table of 2-bit saturating counters (the BHT), which gives a fetch-stage prediction.
- Resolves B-type branches at execute, updates the BHT, and issues a registered redirect/mispredict one cycle later.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- XLEN, 64: operand and PC width.
- BHT_ENTRIES, 64: number of counters; must be a power of 2 and at least 2. IDX_W = $clog2(BHT_ENTRIES).
- CTR_INIT, 2'b01: counter value written during table initialisation (weakly not-taken).
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- pred_valid_i  in  1  fetch-stage lookup request.
- pred_pc_i  in  XLEN  fetch PC.
- pred_taken_o  out  1  combinational prediction: BHT[idx][1] & pred_valid_i & init_done_o.
- res_valid_i  in  1  execute-stage resolve request.
- res_pc_i  in  XLEN  PC of the resolving instruction.
- opr_a_i  in  XLEN  rs1 value.
- opr_b_i  in  XLEN  rs2 value.
- is_b_type_i  in  1  instruction is a conditional branch.
- instr_funct3_i  in  3  branch condition.
- res_pred_taken_i  in  1  prediction that fetch made for this instruction.
- res_target_i  in  XLEN  branch target (PC + imm), computed upstream.
- flush_i  in  1  pipeline flush; kills the resolve in the same cycle.
- res_valid_o  out  1  registered: a resolve result is valid.
- branch_taken_o  out  1  registered: actual outcome.
- mispredict_o  out  1  registered: outcome differs from res_pred_taken_i.
- redirect_pc_o  out  XLEN  registered: correct next PC.
- init_done_o  out  1  BHT initialisation complete.
- branch_cnt_o  out  PERF_W  resolved B-type count, saturating.
- mispred_cnt_o  out  PERF_W  mispredict count, saturating.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - all registered outputs are 0; init_done_o = 0;
  - init pointer = 0; state = INIT.
  - BHT contents are not reset.
- FSM INIT:
  - writes CTR_INIT to BHT[ptr] and increments ptr, one entry per cycle;
  - when ptr == BHT_ENTRIES-1 is written, moves to RUN. Total: BHT_ENTRIES cycles after reset deasserts.
  - In INIT, pred_taken_o = 0 and resolves still produce outputs, but never write the BHT.
- FSM RUN:
  - holds until reset; init_done_o = 1.
- Index: idx = pc[IDX_W+1:2].
- Condition by funct3:
  - 000 BEQ (a==b); 001 BNE (a!=b);
  - 100 BLT (signed a<b); 101 BGE (signed a>=b);
  - 110 BLTU (unsigned a<b); 111 BGEU (unsigned a>=b);
  - 010 and 011: not taken.
- Resolve (res_valid_i & ~flush_i): the registered outputs are valid on the next cycle (latency 1).
  - res_valid_o = 1.
  - B-type: branch_taken_o = cond; mispredict_o = cond ^ res_pred_taken_i.
  - Non-B-type: branch_taken_o = 0, mispredict_o = 0.
  - redirect_pc_o = taken ? res_target_i : res_pc_i + 4, modulo 2^XLEN (wraps).
- Resolve killed (flush_i high, or res_valid_i low): res_valid_o = 0 next cycle; the other outputs hold their last values.
- BHT update, only in RUN on a B-type resolve not killed by flush_i:
  - taken: counter + 1, saturating at 3;
  - not taken: counter - 1, saturating at 0.
- The lookup and update paths are independent. A prediction and an update to the same index in the same cycle: the prediction returns the pre-update value (no bypass).
- Performance counters:
  - branch_cnt_o increments on every B-type resolve not killed by flush_i, in INIT or RUN;
  - mispred_cnt_o increments when mispredict is also set;
  - both stick at all-ones.
- Reset mid-INIT restarts initialisation from entry 0.

Decomposition:
- Shared cpu_consts package:
  - funct3 branch constants (F3_BEQ..F3_BGEU);
  - the 2-bit counter typedef bht_ctr_t;
  - the FSM enum bht_state_e {BHT_INIT, BHT_RUN}.
- One sub-module, branch_cond: the pure comparator (opr_a, opr_b, funct3, is_b_type -> taken), parametrised on XLEN, instantiated once.

Test Plan:
- Init timing:
  - release reset, hold pred_valid_i=1 with pred_pc_i=0x0 -> init_done_o rises exactly 64 cycles later; pred_taken_o = 0 throughout.
  - Then pred_taken_o = 0, since CTR_INIT = 01.
- Comparator sweep, in RUN:
  - a=0xFFFF_FFFF_FFFF_FFFF, b=0x1: BLT -> taken=1; BLTU -> taken=0; BGE -> 0; BGEU -> 1.
  - a=b=0x5: BEQ -> 1; BNE -> 0.
  - funct3=010 -> 0. is_b_type_i=0 with a==b, BEQ -> taken=0, mispredict=0.
- Training:
  - three taken BEQ resolves at res_pc_i=0x1000 -> a lookup of pred_pc_i=0x1000 gives 1 after the first update.
  - Lookup of 0x1000+4*64 gives 1 (alias).
  - Then four not-taken resolves -> prediction 0; counter saturated at 0.
- Redirect and mispredict:
  - res_pred_taken_i=0, taken branch, target 0x2000 -> next cycle res_valid_o=1, mispredict_o=1, redirect_pc_o=0x2000.
  - res_pc_i=0xFFFF_FFFF_FFFF_FFFC, not taken -> redirect_pc_o=0x0.
- Flush and same-cycle conflict:
  - flush_i with res_valid_i -> res_valid_o=0; no BHT or counter change.
  - Lookup and update of the same index in one cycle -> prediction shows the old value; the next cycle shows the new value.
- Reset mid-INIT and counter saturation:
  - assert reset at cycle 30 of INIT -> init_done_o still takes 64 cycles after release.
  - With PERF_W=4, 20 mispredicts -> mispred_cnt_o = 0xF.
